ci_batch_driver: RTL and testbench
==================================

# ci_batch_driver

Master-side driver for the two-operand custom-instruction function-evaluation unit: it drives `clk_en`/`start`/`n`/operands and consumes `done`/`result`. It accepts a stream of 32-bit float operand pairs, issues one CLEAR, one GO per pair and a final READ, then presents the READ result downstream. It sits between the operand buffer or DMA front end and the function-evaluation slave, so a batch runs without per-instruction CPU involvement.

## Interface
Parameters:
- `FLT_DATA_WIDTH`, 32, operand/result width
- `N_WIDTH`, 2, opcode width
- `CNT_WIDTH`, 16, pair-counter width
- `TIMEOUT_CYCLES`, 1024, watchdog limit per instruction (only with `CI_DRIVER_TIMEOUT_EN`)

Ports:
- `clk`  in  1  single clock, all logic on posedge
- `rst`  in  1  synchronous, active-high reset
- `in_valid`  in  1  operand pair available
- `in_ready`  out  1  driver accepts pair
- `in_x_one`, `in_x_two`  in  FLT_DATA_WIDTH  operands
- `in_last`  in  1  marks final pair of batch
- `ci_clk_en`  out  1  slave clock enable
- `ci_start`  out  1  one-cycle instruction strobe
- `ci_n`  out  N_WIDTH  opcode: CLEAR=0, GO=1, READ=2
- `ci_x_one`, `ci_x_two`  out  FLT_DATA_WIDTH  operands to slave
- `ci_done`  in  1  slave completion pulse
- `ci_result`  in  FLT_DATA_WIDTH  slave result, valid with `ci_done`
- `out_valid`  out  1  batch result available
- `out_ready`  in  1  consumer accepts result
- `out_sum`  out  FLT_DATA_WIDTH  captured READ result
- `pair_count`  out  CNT_WIDTH  GO instructions completed in current batch
- `busy`  out  1  high in every state except IDLE
- `timeout_err`  out  1  sticky watchdog flag

## Operation
- States: IDLE, CLR_ISSUE, CLR_WAIT, FETCH, GO_ISSUE, GO_WAIT, RD_ISSUE, RD_WAIT, OUTPUT, ERROR.
- IDLE: `in_ready`=0. When `in_valid`=1, go to CLR_ISSUE. The pair is not consumed.
- CLR_ISSUE: `ci_start`=1, `ci_n`=0. Clear `pair_count`. Go to CLR_WAIT.
- CLR_WAIT: on `ci_done`, go to FETCH.
- FETCH: `in_ready`=1. On `in_valid`, latch both operands and `in_last` into holding registers, then go to GO_ISSUE.
- GO_ISSUE: `ci_start`=1, `ci_n`=1. Go to GO_WAIT.
- GO_WAIT: on `ci_done`, increment `pair_count`, which saturates at all-ones. Go to RD_ISSUE if latched last=1, else go to FETCH.
- RD_ISSUE: `ci_start`=1, `ci_n`=2. Go to RD_WAIT.
- RD_WAIT: on `ci_done`, capture `ci_result` into `out_sum` and go to OUTPUT.
- OUTPUT: `out_valid`=1. `out_sum` and `pair_count` are stable. On `out_ready`, go to IDLE.
- `ci_x_one`/`ci_x_two` always drive the holding registers. They change only in FETCH and are stable from `ci_start` through `ci_done`.
- `ci_clk_en`=1 in every *_ISSUE and *_WAIT state, 0 elsewhere.
- `ci_done` is ignored outside *_WAIT states.
- `in_ready` is high only in FETCH.
- The unit sends no result for a batch until READ completes.

## Timing
- Reset values: `in_ready`=0, `ci_clk_en`=0, `ci_start`=0, `ci_n`=0, `ci_x_one`=0, `ci_x_two`=0, `out_valid`=0, `out_sum`=0, `pair_count`=0, `busy`=0, `timeout_err`=0. State resets to IDLE.
- All outputs are registered.
- `ci_start` is exactly one cycle high. The earliest `ci_done` is accepted the cycle after `ci_start`.
- Each instruction takes 1 + L cycles, where L is the slave latency from `start` to `done`, L ≥ 1.
- Each pair additionally takes 1 FETCH cycle, or more while `in_valid`=0.
- Batch of K pairs: (1+L_clr) + K·(2+L_go) + (1+L_rd) cycles to `out_valid`, plus 1 cycle in IDLE.
- `in_valid` may drop in FETCH. The driver waits there indefinitely with `ci_clk_en`=0.
- `out_ready` held high in OUTPUT returns the driver to IDLE in 1 cycle. A new batch can start on the following cycle.
- `rst` mid-instruction: immediate return to IDLE with all reset values. The slave is not flushed; the next batch's CLEAR resets it.

## Configuration
- `CI_DRIVER_TIMEOUT_EN` defined:
  - A counter clears on every *_ISSUE state and increments each *_WAIT cycle without `ci_done`.
  - On reaching `TIMEOUT_CYCLES`, go to ERROR and set `timeout_err`=1.
  - ERROR holds `busy`=1, `ci_clk_en`=0, `in_ready`=0 and `out_valid`=0 until `rst`.
- Undefined: no counter and no ERROR state. `timeout_err` is tied 0, and *_WAIT states wait indefinitely.

## Test plan
- Single pair (1.0, 2.0) with `in_last`=1, slave L=3:
  - Opcode sequence on `ci_n` at the `ci_start` strobes is 0, 1, 2.
  - `ci_result`=0x40400000 at READ → `out_sum`=0x40400000, `pair_count`=1.
  - `out_valid` rises 14 cycles after the first `in_valid`.
- Batch of 4 pairs, `in_valid` deasserted 5 cycles between pairs 2 and 3 → driver holds FETCH, no extra `ci_start` pulse, `pair_count`=4 at OUTPUT.
- `out_ready` held 0 for 10 cycles in OUTPUT → `out_valid` and `out_sum` stable, `in_ready`=0 throughout; `out_ready`=1 → IDLE next cycle.
- `ci_done` pulses while in FETCH and in OUTPUT → ignored; state and `pair_count` unchanged.
- `rst` asserted in GO_WAIT of pair 2 → next cycle all outputs at reset values. A fresh batch then starts with CLEAR.
- With `CI_DRIVER_TIMEOUT_EN`, `TIMEOUT_CYCLES`=8, slave never asserts `ci_done` → `timeout_err`=1 after 8 GO_WAIT cycles; stays 1 until `rst`. Without the macro, the driver remains in GO_WAIT and `timeout_err`=0.

Source files
------------

// File: rtl/ci_batch_driver.sv
// Master-side batch sequencer for the function-evaluation slave: CLEAR, one GO per operand pair, then READ.
// Optional per-instruction watchdog with ERROR state when CI_DRIVER_TIMEOUT_EN is defined.
module ci_batch_driver #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2,
    parameter int CNT_WIDTH      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [FLT_DATA_WIDTH-1:0] in_x_one,
    input  logic [FLT_DATA_WIDTH-1:0] in_x_two,
    input  logic                      in_last,
    output logic                      ci_clk_en,
    output logic                      ci_start,
    output logic [N_WIDTH-1:0]        ci_n,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_one,
    output logic [FLT_DATA_WIDTH-1:0] ci_x_two,
    input  logic                      ci_done,
    input  logic [FLT_DATA_WIDTH-1:0] ci_result,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [FLT_DATA_WIDTH-1:0] out_sum,
    output logic [CNT_WIDTH-1:0]      pair_count,
    output logic                      busy,
    output logic                      timeout_err
);

    // state      | meaning
    // IDLE       | waiting for the first pair of a batch (pair not consumed)
    // CLR_ISSUE  | CLEAR strobe to the slave
    // CLR_WAIT   | waiting for CLEAR done
    // FETCH      | accepting the next operand pair
    // GO_ISSUE   | GO strobe with the held operands
    // GO_WAIT    | waiting for GO done, then next pair or READ
    // RD_ISSUE   | READ strobe
    // RD_WAIT    | waiting for READ done, result captured
    // OUTPUT     | presenting the batch result downstream
    // ERROR      | watchdog expired, held until reset (timeout build only)
    typedef enum logic [3:0] {
        S_IDLE,
        S_CLR_ISSUE,
        S_CLR_WAIT,
        S_FETCH,
        S_GO_ISSUE,
        S_GO_WAIT,
        S_RD_ISSUE,
        S_RD_WAIT,
        S_OUTPUT
`ifdef CI_DRIVER_TIMEOUT_EN
        , S_ERROR
`endif
    } state_t;

    localparam logic [N_WIDTH-1:0] N_CLEAR = N_WIDTH'(0);
    localparam logic [N_WIDTH-1:0] N_GO    = N_WIDTH'(1);
    localparam logic [N_WIDTH-1:0] N_READ  = N_WIDTH'(2);

    state_t state, state_nxt;
    logic   hold_last;
    logic   issue_nxt, wait_nxt;

`ifdef CI_DRIVER_TIMEOUT_EN
    localparam int WD_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYCLES - 1);

    logic [WD_W-1:0] wd_cnt;
    logic            issue_cur, wait_cur, wd_expire;

    assign issue_cur = (state == S_CLR_ISSUE) || (state == S_GO_ISSUE) || (state == S_RD_ISSUE);
    assign wait_cur  = (state == S_CLR_WAIT) || (state == S_GO_WAIT) || (state == S_RD_WAIT);
    assign wd_expire = wait_cur && !ci_done && (wd_cnt == WD_LAST);

    always_ff @(posedge clk) begin
        if (rst || issue_cur) begin
            wd_cnt <= '0;
        end else if (wait_cur && !ci_done && !wd_expire) begin
            wd_cnt <= wd_cnt + WD_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            timeout_err <= 1'b0;
        end else if (state_nxt == S_ERROR) begin
            timeout_err <= 1'b1;
        end
    end
`else
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("TIMEOUT_CYCLES must be at least 1");
    end
    assign timeout_err = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE:      if (in_valid) state_nxt = S_CLR_ISSUE;
            S_CLR_ISSUE: state_nxt = S_CLR_WAIT;
            S_CLR_WAIT:  if (ci_done) state_nxt = S_FETCH;
            S_FETCH:     if (in_valid) state_nxt = S_GO_ISSUE;
            S_GO_ISSUE:  state_nxt = S_GO_WAIT;
            S_GO_WAIT:   if (ci_done) state_nxt = hold_last ? S_RD_ISSUE : S_FETCH;
            S_RD_ISSUE:  state_nxt = S_RD_WAIT;
            S_RD_WAIT:   if (ci_done) state_nxt = S_OUTPUT;
            S_OUTPUT:    if (out_ready) state_nxt = S_IDLE;
`ifdef CI_DRIVER_TIMEOUT_EN
            S_ERROR:     state_nxt = S_ERROR;
`endif
            default:     state_nxt = S_IDLE;
        endcase
`ifdef CI_DRIVER_TIMEOUT_EN
        if (wd_expire) state_nxt = S_ERROR;
`endif
    end

    // Outputs are registered from the next state so they line up with the state register.
    always_comb begin
        issue_nxt = (state_nxt == S_CLR_ISSUE) || (state_nxt == S_GO_ISSUE) ||
                    (state_nxt == S_RD_ISSUE);
        wait_nxt  = (state_nxt == S_CLR_WAIT) || (state_nxt == S_GO_WAIT) ||
                    (state_nxt == S_RD_WAIT);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            in_ready   <= 1'b0;
            ci_clk_en  <= 1'b0;
            ci_start   <= 1'b0;
            ci_n       <= N_CLEAR;
            ci_x_one   <= '0;
            ci_x_two   <= '0;
            hold_last  <= 1'b0;
            out_valid  <= 1'b0;
            out_sum    <= '0;
            pair_count <= '0;
            busy       <= 1'b0;
        end else begin
            state     <= state_nxt;
            in_ready  <= (state_nxt == S_FETCH);
            ci_clk_en <= issue_nxt || wait_nxt;
            ci_start  <= issue_nxt;
            out_valid <= (state_nxt == S_OUTPUT);
            busy      <= (state_nxt != S_IDLE);

            case (state_nxt)
                S_CLR_ISSUE: ci_n <= N_CLEAR;
                S_GO_ISSUE:  ci_n <= N_GO;
                S_RD_ISSUE:  ci_n <= N_READ;
                default:     ;
            endcase

            // Operands to the slave are the holding registers themselves.
            if (state == S_FETCH && in_valid) begin
                ci_x_one  <= in_x_one;
                ci_x_two  <= in_x_two;
                hold_last <= in_last;
            end

            if (state == S_IDLE && in_valid) begin
                pair_count <= '0;
            end else if (state == S_GO_WAIT && ci_done && (pair_count != '1)) begin
                pair_count <= pair_count + CNT_WIDTH'(1);
            end

            if (state == S_RD_WAIT && ci_done) begin
                out_sum <= ci_result;
            end
        end
    end

endmodule

// File: tb/tb_ci_batch_driver.sv
// Scoreboard bench for ci_batch_driver: randomized batches against a behavioural slave and batch-level reference model.
module tb_ci_batch_driver;

    localparam int TO = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_x_one = '0;
    logic [31:0] in_x_two = '0;
    logic        in_last = 1'b0;
    logic        out_ready = 1'b1;
    logic        slave_done = 1'b0;
    logic        stray_done = 1'b0;
    logic        ci_done;
    logic [31:0] ci_result = '0;

    logic        in_ready, ci_clk_en, ci_start, out_valid, busy, timeout_err;
    logic [1:0]  ci_n;
    logic [31:0] ci_x_one, ci_x_two, out_sum;
    logic [15:0] pair_count;

    assign ci_done = slave_done | stray_done;

    ci_batch_driver #(
        .FLT_DATA_WIDTH(32), .N_WIDTH(2), .CNT_WIDTH(16), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_x_one(in_x_one), .in_x_two(in_x_two), .in_last(in_last),
        .ci_clk_en(ci_clk_en), .ci_start(ci_start), .ci_n(ci_n),
        .ci_x_one(ci_x_one), .ci_x_two(ci_x_two),
        .ci_done(ci_done), .ci_result(ci_result),
        .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum),
        .pair_count(pair_count), .busy(busy), .timeout_err(timeout_err)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge clk) cyc++;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct packed {
        logic [31:0] sum;
        logic [15:0] cnt;
    } exp_t;

    exp_t exp_q[$];
    int   op_q[$];

    // Behavioural slave: responds L cycles after each start; READ returns the running sum of GO operands.
    int          cd = 0;
    int          lat_cfg = 3;
    bit          lat_rand = 1'b0;
    bit          silent = 1'b0;
    bit          fixed_en = 1'b0;
    logic [31:0] fixed_val = '0;
    logic [31:0] acc = '0;
    int          start_cnt = 0;

    always @(negedge clk) begin
        slave_done = 1'b0;
        if (rst) begin
            cd = 0;
        end else begin
            if (cd > 0) begin
                cd--;
                if (cd == 0) slave_done = 1'b1;
            end
            if (ci_start) begin
                int exp_op;
                start_cnt++;
                chk("start_expected", 128'(op_q.size() != 0), 128'(1));
                chk("clk_en_at_start", 128'(ci_clk_en), 128'(1));
                if (op_q.size() != 0) begin
                    exp_op = op_q.pop_front();
                    chk("opcode", 128'(ci_n), 128'(exp_op));
                end
                if (ci_n == 2'd0) acc = '0;
                if (ci_n == 2'd1) acc = acc + ci_x_one + ci_x_two;
                ci_result = (ci_n == 2'd2) ? (fixed_en ? fixed_val : acc) : $urandom;
                if (!silent) cd = lat_rand ? int'($urandom_range(1, 5)) : lat_cfg;
            end
        end
    end

    // Monitor: pops an expectation when a result appears, checks it for as long as it is held.
    bit   prev_ov = 1'b0;
    exp_t cur;
    int   rise_cyc = 0;

    always @(negedge clk) begin
        if (rst) begin
            prev_ov = 1'b0;
        end else begin
            if (out_valid && !prev_ov) begin
                rise_cyc = cyc;
                chk("result_expected", 128'(exp_q.size() != 0), 128'(1));
                if (exp_q.size() != 0) cur = exp_q.pop_front();
            end
            if (out_valid) begin
                chk("out_sum", 128'(out_sum), 128'(cur.sum));
                chk("pair_count", 128'(pair_count), 128'(cur.cnt));
                chk("in_ready_in_output", 128'(in_ready), 128'(0));
            end
            prev_ov = out_valid;
        end
    end

    function automatic logic [127:0] out_vec();
        return 128'({in_ready, ci_clk_en, ci_start, ci_n, ci_x_one, ci_x_two,
                     out_valid, out_sum, pair_count, busy, timeout_err});
    endfunction

    task automatic send_pair(input logic [31:0] a, input logic [31:0] b, input bit last);
        bit got = 1'b0;
        in_x_one = a;
        in_x_two = b;
        in_last  = last;
        in_valid = 1'b1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (in_ready) begin
                got = 1'b1;
                break;
            end
        end
        chk("pair_accepted", 128'(got), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic run_batch(input int k, input int gap_after, input int hold);
        logic [31:0] xa[$];
        logic [31:0] xb[$];
        logic [31:0] sum = '0;
        logic [15:0] pc;
        exp_t        e;
        int          s0;
        bit          got;
        for (int i = 0; i < k; i++) begin
            xa.push_back($urandom);
            xb.push_back($urandom);
            sum = sum + xa[i] + xb[i];
        end
        op_q.push_back(0);
        repeat (k) op_q.push_back(1);
        op_q.push_back(2);
        e.sum = sum;
        e.cnt = 16'(k);
        exp_q.push_back(e);
        s0 = start_cnt;
        out_ready = (hold == 0);
        for (int i = 0; i < k; i++) begin
            send_pair(xa[i], xb[i], i == k - 1);
            if (i == gap_after) begin
                got = 1'b0;
                for (int j = 0; j < 50; j++) begin
                    @(negedge clk);
                    if (in_ready) begin
                        got = 1'b1;
                        break;
                    end
                end
                chk("reach_fetch", 128'(got), 128'(1));
                pc = pair_count;
                stray_done = 1'b1;
                @(negedge clk);
                stray_done = 1'b0;
                chk("fetch_stray_state", 128'({in_ready, ci_clk_en, ci_start}), 128'(3'b100));
                chk("fetch_stray_count", 128'(pair_count), 128'(pc));
                repeat (4) @(negedge clk);
                chk("fetch_hold", 128'({in_ready, ci_clk_en, ci_start}), 128'(3'b100));
                @(posedge clk);
                #1;
            end else begin
                repeat ($urandom_range(0, 2)) begin
                    @(posedge clk);
                    #1;
                end
            end
        end
        if (hold > 0) begin
            got = 1'b0;
            for (int j = 0; j < 2000; j++) begin
                @(negedge clk);
                if (out_valid) begin
                    got = 1'b1;
                    break;
                end
            end
            chk("reach_output", 128'(got), 128'(1));
            for (int j = 0; j < hold; j++) begin
                stray_done = (j == 3);
                @(negedge clk);
                chk("hold_valid", 128'({out_valid, busy, in_ready}), 128'(3'b110));
            end
            stray_done = 1'b0;
            out_ready = 1'b1;
            @(negedge clk);
            chk("release_to_idle", 128'({out_valid, busy}), 128'(0));
        end
        for (int j = 0; j < 3000; j++) begin
            @(negedge clk);
            if (hold == 0) out_ready = 1'($urandom_range(0, 1));
            if (!busy) break;
        end
        chk("batch_done", 128'(busy), 128'(0));
        chk("start_pulses", 128'(start_cnt - s0), 128'(k + 2));
        out_ready = 1'b1;
    endtask

    initial begin
        int   start_cyc;
        int   wcnt;
        exp_t e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_values", out_vec(), 128'(0));
        rst = 1'b0;
        @(posedge clk);
        #1;

        // Single pair 1.0 + 2.0, fixed latency 3
        fixed_en  = 1'b1;
        fixed_val = 32'h4040_0000;
        lat_cfg   = 3;
        op_q.push_back(0);
        op_q.push_back(1);
        op_q.push_back(2);
        e.sum = 32'h4040_0000;
        e.cnt = 16'd1;
        exp_q.push_back(e);
        start_cyc = cyc;
        send_pair(32'h3F80_0000, 32'h4000_0000, 1'b1);
        for (int j = 0; j < 200; j++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("single_done", 128'(busy), 128'(0));
        chk("single_latency", 128'(rise_cyc - start_cyc), 128'(14));
        fixed_en = 1'b0;

        // Four pairs with a stall after pair 2, random latencies
        lat_rand = 1'b1;
        run_batch(4, 1, 0);

        // Output held by the consumer for 10 cycles
        run_batch(3, -1, 10);

        // Reset while GO of pair 2 is outstanding
        lat_rand = 1'b0;
        lat_cfg  = 6;
        op_q.push_back(0);
        op_q.push_back(1);
        op_q.push_back(1);
        send_pair($urandom, $urandom, 1'b0);
        send_pair($urandom, $urandom, 1'b0);
        @(negedge clk);
        @(negedge clk);
        chk("in_go_wait", 128'({ci_clk_en, ci_start, ci_n, pair_count}), 128'({1'b1, 1'b0, 2'd1, 16'd1}));
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        chk("mid_reset_values", out_vec(), 128'(0));
        repeat (10) @(negedge clk);
        lat_rand = 1'b1;
        run_batch(3, -1, 0);

        for (int b = 0; b < 6; b++) begin
            run_batch(int'($urandom_range(1, 6)), -1, 0);
        end

        // Slave that never completes a GO
        lat_rand = 1'b0;
        lat_cfg  = 2;
        op_q.push_back(0);
        op_q.push_back(1);
        send_pair($urandom, $urandom, 1'b1);
        silent = 1'b1;
`ifdef CI_DRIVER_TIMEOUT_EN
        wcnt = 0;
        for (int j = 0; j < 100; j++) begin
            @(negedge clk);
            if (timeout_err) break;
            if (ci_clk_en && !ci_start && busy) wcnt++;
        end
        chk("timeout_raised", 128'(timeout_err), 128'(1));
        chk("timeout_wait_cycles", 128'(wcnt), 128'(TO));
        repeat (5) @(negedge clk);
        chk("error_hold", 128'({timeout_err, busy, ci_clk_en, in_ready, out_valid}), 128'(5'b11000));
`else
        wcnt = 0;
        repeat (40) @(negedge clk);
        chk("wait_forever", 128'({timeout_err, busy, ci_clk_en, ci_start, ci_n}), 128'({1'b0, 1'b1, 1'b1, 1'b0, 2'd1}));
`endif
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        silent = 1'b0;
        @(negedge clk);
        chk("post_timeout_reset", out_vec(), 128'(0));

        repeat (5) @(negedge clk);
        chk("results_drained", 128'(exp_q.size()), 128'(0));
        chk("opcodes_drained", 128'(op_q.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish, checks=%0d failures=%0d", n_checks, n_fail);
        $fatal(1, "time limit");
    end

endmodule
